// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter_pkg
// Brief    : Shared FSM encoding and defaults for the data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_PEND  = 2'd1,
        DMA_ISSUE = 2'd2,
        DMA_ACK   = 2'd3
    } dma_state_t;

    localparam int c_DEFAULT_MAX_WAIT = 15;
    localparam int c_WAIT_W           = 8;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter_if
// Brief    : CPU, debug and SPRAM signal bundle around the data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_lock;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_wren;
    logic [3:0]        ram_maskwren;
    logic [DATA_W-1:0] ram_dout;

    // Arbiter view
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_ack, dbg_rdata,
        output ram_addr, ram_din, ram_wren, ram_maskwren,
        input  ram_dout
    );

    // Requester / memory view
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_ack, dbg_rdata,
        input  ram_addr, ram_din, ram_wren, ram_maskwren,
        output ram_dout
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Shares the data SPRAM between the CPU port (priority) and a debug
//            port with a starvation bound and a CPU freeze lock.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = c_DEFAULT_MAX_WAIT
) (
    input  wire logic         clock,
    input  wire logic         reset,
    data_mem_arbiter_if.slave bus
);

    localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT = c_WAIT_W'(MAX_WAIT);

    dma_state_t          r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_dbg_ack;
    logic [DATA_W-1:0]   r_dbg_rdata;

    logic                w_dbg_grant;
    logic                w_cpu_grant;
    logic                w_ram_wren;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]   w_ram_din;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= DMA_IDLE;
            r_wait_cnt  <= '0;
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            r_dbg_ack <= 1'b0;
            case (r_state)
                DMA_IDLE: begin
                    if (bus.dbg_req) begin
                        r_state    <= DMA_PEND;
                        r_wait_cnt <= '0;
                    end
                end
                DMA_PEND: begin
                    if (r_wait_cnt != c_WAIT_LIMIT) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                    if (!bus.cpu_req || bus.dbg_lock || (r_wait_cnt == c_WAIT_LIMIT)) begin
                        r_state <= DMA_ISSUE;
                    end
                end
                DMA_ISSUE: begin
                    r_state   <= DMA_ACK;
                    r_dbg_ack <= 1'b1;
                end
                DMA_ACK: begin
                    // Keep the returned word so dbg_rdata stays stable afterwards
                    r_state     <= DMA_IDLE;
                    r_dbg_rdata <= bus.ram_dout;
                end
                default: r_state <= DMA_IDLE;
            endcase
        end
    end

    assign w_dbg_grant = (r_state == DMA_ISSUE);
    assign w_cpu_grant = bus.cpu_req & ~bus.dbg_lock & ~w_dbg_grant;

    // With no owner the muxes rest on the CPU port and the write is suppressed
    assign w_ram_addr = w_dbg_grant ? bus.dbg_addr  : bus.cpu_addr;
    assign w_ram_din  = w_dbg_grant ? bus.dbg_wdata : bus.cpu_wdata;
    assign w_ram_wren = w_dbg_grant ? bus.dbg_we    : (w_cpu_grant & bus.cpu_we);

    assign bus.ram_addr     = w_ram_addr;
    assign bus.ram_din      = w_ram_din;
    assign bus.ram_wren     = w_ram_wren;
    assign bus.ram_maskwren = {4{w_ram_wren}};

    assign bus.cpu_stall = bus.cpu_req & (bus.dbg_lock | w_dbg_grant);
    assign bus.cpu_rdata = bus.ram_dout;

    // SPRAM output is already registered: in ACK it carries the debug word directly
    assign bus.dbg_ack   = r_dbg_ack;
    assign bus.dbg_rdata = (r_state == DMA_ACK) ? bus.ram_dout : r_dbg_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Brief    : Self-checking bench for data_mem_arbiter with an SPRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 16;
    localparam int MAX_WAIT = 15;
    localparam int TIMEOUT  = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   wr_count = 0;

    logic [DATA_W-1:0] ram_arr   [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem   [0:(1<<ADDR_W)-1];
    bit                ref_valid [0:(1<<ADDR_W)-1];

    data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    data_mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // SPRAM behaviour: synchronous write, registered read
    always @(posedge clock) begin
        if (bus.ram_wren) begin
            ram_arr[bus.ram_addr] <= bus.ram_din;
            wr_count <= wr_count + 1;
        end else begin
            bus.ram_dout <= ram_arr[bus.ram_addr];
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        bus.dbg_lock = 1'b0;
    endtask

    task automatic ref_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ref_mem[a]   = d;
        ref_valid[a] = 1'b1;
    endtask

    // Runs one debug transaction with CPU idle or reading every cycle; the expected
    // ack latency follows the release rule: first PEND cycle with no CPU request,
    // lock high, or MAX_WAIT cycles already waited.
    task automatic run_dbg(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input bit cpu_busy, input bit lock,
                           output int lat, output int exp_lat, output int stall_cnt,
                           output int wren_cnt, output logic [DATA_W-1:0] rd);
        lat = -1; exp_lat = -1; stall_cnt = 0; wren_cnt = 0; rd = '0;
        bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd;
        bus.dbg_lock = lock;
        for (int c = 0; c < TIMEOUT && lat < 0; c++) begin
            bus.cpu_req   = cpu_busy;
            bus.cpu_we    = 1'b0;
            bus.cpu_addr  = ADDR_W'($urandom_range(0, (1<<ADDR_W)-1));
            bus.cpu_wdata = '0;
            if (c >= 1 && exp_lat < 0 && (!cpu_busy || lock || (c - 1) == MAX_WAIT))
                exp_lat = c + 2;
            @(negedge clock);
            if (bus.cpu_stall) stall_cnt++;
            if (bus.ram_wren)  wren_cnt++;
            if (bus.dbg_ack) begin
                lat = c;
                rd  = bus.dbg_rdata;
            end
            next_cycle();
        end
        set_idle();
        if (we && lat >= 0) ref_write(addr, wd);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_idle();
        bus.cpu_req = 1'b1;
        repeat (3) next_cycle();
        @(negedge clock);
        total++; if (dut.r_state !== DMA_IDLE) begin bad++; $display("FAIL reset_state: got %0d expected %0d", dut.r_state, DMA_IDLE); end
        total++; if (dut.r_wait_cnt !== 8'd0) begin bad++; $display("FAIL reset_wait_cnt: got %0d expected 0", dut.r_wait_cnt); end
        total++; if (bus.dbg_ack !== 1'b0) begin bad++; $display("FAIL reset_dbg_ack: got %b expected 0", bus.dbg_ack); end
        total++; if (bus.dbg_rdata !== 16'h0000) begin bad++; $display("FAIL reset_dbg_rdata: got %h expected 0000", bus.dbg_rdata); end
        total++; if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_cpu_stall: got %b expected 0", bus.cpu_stall); end
        total++; if (bus.ram_wren !== 1'b0) begin bad++; $display("FAIL reset_ram_wren: got %b expected 0", bus.ram_wren); end
        next_cycle();
        bus.dbg_lock = 1'b1;
        @(negedge clock);
        total++; if (bus.cpu_stall !== 1'b1) begin bad++; $display("FAIL reset_lock_stall: got %b expected 1", bus.cpu_stall); end
        next_cycle();
        reset = 1'b0;
        set_idle();
        next_cycle();
    endtask

    task automatic test_dbg_write_idle();
        int lat, exp_lat, sc, wc;
        logic [DATA_W-1:0] rd;
        run_dbg(1'b1, 14'h0005, 16'h1234, 1'b0, 1'b0, lat, exp_lat, sc, wc, rd);
        total++; if (lat !== exp_lat) begin bad++; $display("FAIL idle_write_latency: got %0d expected %0d", lat, exp_lat); end
        total++; if (wc !== 1) begin bad++; $display("FAIL idle_write_count: got %0d expected 1", wc); end
        bus.cpu_req = 1'b1; bus.cpu_addr = 14'h0005;
        @(negedge clock);
        total++; if (bus.cpu_stall !== 1'b0 || sc !== 0) begin bad++; $display("FAIL idle_cpu_stall: got %b/%0d expected 0/0", bus.cpu_stall, sc); end
        next_cycle();
        bus.cpu_req = 1'b0;
        @(negedge clock);
        total++; if (bus.cpu_rdata !== ref_mem[14'h0005]) begin bad++; $display("FAIL idle_cpu_readback: got %h expected %h", bus.cpu_rdata, ref_mem[14'h0005]); end
        next_cycle();
    endtask

    task automatic test_starvation();
        int lat, exp_lat, sc, wc;
        logic [DATA_W-1:0] rd, d;
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom_range(16'h0400, 16'h0FFF));
        d = DATA_W'($urandom);
        run_dbg(1'b1, a, d, 1'b0, 1'b0, lat, exp_lat, sc, wc, rd);
        run_dbg(1'b0, a, '0, 1'b1, 1'b0, lat, exp_lat, sc, wc, rd);
        total++; if (lat !== exp_lat || lat > 18) begin bad++; $display("FAIL starve_latency: got %0d expected %0d", lat, exp_lat); end
        total++; if (sc !== 1) begin bad++; $display("FAIL starve_stall_cycles: got %0d expected 1", sc); end
        total++; if (rd !== ref_mem[a]) begin bad++; $display("FAIL starve_rdata: got %h expected %h", rd, ref_mem[a]); end
    endtask

    task automatic test_lock();
        int lat, exp_lat, sc, wc;
        logic [DATA_W-1:0] rd, d;
        d = DATA_W'($urandom);
        run_dbg(1'b1, 14'h3FFF, d, 1'b0, 1'b0, lat, exp_lat, sc, wc, rd);
        run_dbg(1'b0, 14'h3FFF, '0, 1'b1, 1'b1, lat, exp_lat, sc, wc, rd);
        total++; if (lat !== exp_lat) begin bad++; $display("FAIL lock_latency: got %0d expected %0d", lat, exp_lat); end
        total++; if (sc !== lat + 1) begin bad++; $display("FAIL lock_stall_cycles: got %0d expected %0d", sc, lat + 1); end
        total++; if (wc !== 0) begin bad++; $display("FAIL lock_ram_wren: got %0d expected 0", wc); end
        total++; if (rd !== ref_mem[14'h3FFF]) begin bad++; $display("FAIL lock_rdata: got %h expected %h", rd, ref_mem[14'h3FFF]); end
    endtask

    task automatic test_back_to_back();
        int acks [2];
        int n, w0;
        bit switch_op;
        logic [ADDR_W-1:0] a0, a1;
        logic [DATA_W-1:0] d0, d1;
        a0 = ADDR_W'($urandom_range(16'h1000, 16'h1FFE)); a1 = a0 + 1'b1;
        d0 = DATA_W'($urandom); d1 = ~d0;
        n = 0; w0 = wr_count; switch_op = 1'b0;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = a0; bus.dbg_wdata = d0;
        for (int c = 0; c < TIMEOUT && n < 2; c++) begin
            @(negedge clock);
            switch_op = 1'b0;
            if (bus.dbg_ack) begin acks[n] = c; n++; switch_op = (n == 1); end
            next_cycle();
            if (switch_op) begin bus.dbg_addr = a1; bus.dbg_wdata = d1; end
        end
        set_idle();
        ref_write(a0, d0); ref_write(a1, d1);
        total++; if (n !== 2) begin bad++; $display("FAIL b2b_ack_count: got %0d expected 2", n); end
        else begin
            total++; if (acks[1] - acks[0] < 4 || acks[1] - acks[0] !== 4) begin bad++; $display("FAIL b2b_spacing: got %0d expected 4", acks[1] - acks[0]); end
        end
        total++; if (wr_count - w0 !== 2) begin bad++; $display("FAIL b2b_ram_writes: got %0d expected 2", wr_count - w0); end
        for (int k = 0; k < 2; k++) begin
            logic [ADDR_W-1:0] a;
            a = (k == 0) ? a0 : a1;
            bus.cpu_req = 1'b1; bus.cpu_addr = a;
            next_cycle();
            bus.cpu_req = 1'b0;
            @(negedge clock);
            total++; if (bus.cpu_rdata !== ref_mem[a]) begin bad++; $display("FAIL b2b_readback%0d: got %h expected %h", k, bus.cpu_rdata, ref_mem[a]); end
            next_cycle();
        end
    endtask

    task automatic test_reset_in_issue();
        int acks;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 14'h0200; bus.dbg_wdata = DATA_W'($urandom);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        total++; if (bus.ram_wren !== 1'b1) begin bad++; $display("FAIL rst_issue_wren_before: got %b expected 1", bus.ram_wren); end
        next_cycle();
        reset = 1'b0;
        bus.dbg_req = 1'b0;
        @(negedge clock);
        total++; if (dut.r_state !== DMA_IDLE || bus.dbg_ack !== 1'b0 || bus.ram_wren !== 1'b0) begin
            bad++; $display("FAIL rst_issue_after: got state=%0d ack=%b wren=%b expected 0/0/0", dut.r_state, bus.dbg_ack, bus.ram_wren);
        end
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge clock);
            if (bus.dbg_ack) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL rst_issue_no_ack: got %0d expected 0", acks); end
        next_cycle();
        set_idle();
    endtask

    task automatic test_collision();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 14'h0100; bus.dbg_wdata = 16'h5555;
        next_cycle();
        next_cycle();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0100; bus.cpu_wdata = 16'hAAAA;
        @(negedge clock);
        total++; if (bus.cpu_stall !== 1'b1 || bus.ram_wren !== 1'b1 || bus.ram_din !== 16'h5555) begin
            bad++; $display("FAIL collide_issue: got stall=%b wren=%b din=%h expected 1/1/5555", bus.cpu_stall, bus.ram_wren, bus.ram_din);
        end
        next_cycle();
        bus.dbg_req = 1'b0;
        @(negedge clock);
        total++; if (bus.cpu_stall !== 1'b0 || bus.ram_wren !== 1'b1 || bus.ram_din !== 16'hAAAA || bus.dbg_ack !== 1'b1) begin
            bad++; $display("FAIL collide_retry: got stall=%b wren=%b din=%h ack=%b expected 0/1/aaaa/1", bus.cpu_stall, bus.ram_wren, bus.ram_din, bus.dbg_ack);
        end
        ref_write(14'h0100, 16'h5555);
        ref_write(14'h0100, 16'hAAAA);
        next_cycle();
        bus.cpu_we = 1'b0;
        next_cycle();
        bus.cpu_req = 1'b0;
        @(negedge clock);
        total++; if (bus.cpu_rdata !== ref_mem[14'h0100]) begin bad++; $display("FAIL collide_final: got %h expected %h", bus.cpu_rdata, ref_mem[14'h0100]); end
        next_cycle();
        set_idle();
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            logic dwe, acked, rd_pend, dv;
            logic [ADDR_W-1:0] da;
            logic [DATA_W-1:0] dd, exp_rd, rd_exp;
            bit lock;
            int issue_c;
            dwe = 1'($urandom_range(0, 1));
            da  = ADDR_W'($urandom_range(0, 15));
            dd  = DATA_W'($urandom);
            lock = ($urandom_range(0, 4) == 0);
            issue_c = -1; acked = 1'b0; rd_pend = 1'b0; dv = 1'b0; exp_rd = '0; rd_exp = '0;
            bus.dbg_req = 1'b1; bus.dbg_we = dwe; bus.dbg_addr = da; bus.dbg_wdata = dd;
            bus.dbg_lock = lock;
            for (int c = 0; c < TIMEOUT && !acked; c++) begin
                logic creq, cwe, is_issue, exp_ack, exp_stall, granted;
                logic [ADDR_W-1:0] ca;
                logic [DATA_W-1:0] cd;
                creq = ($urandom_range(0, 9) < 8);
                cwe  = ($urandom_range(0, 2) == 0);
                ca   = ADDR_W'($urandom_range(0, 15));
                cd   = DATA_W'($urandom);
                bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cd;
                if (c >= 1 && issue_c < 0 && (!creq || lock || (c - 1) == MAX_WAIT)) issue_c = c + 1;
                is_issue  = (c == issue_c);
                exp_ack   = (issue_c >= 0 && c == issue_c + 1);
                exp_stall = creq & (lock | is_issue);
                granted   = creq & ~lock & ~is_issue;
                @(negedge clock);
                if (rd_pend) begin
                    total++; if (bus.cpu_rdata !== rd_exp) begin bad++; $display("FAIL rand_cpu_rdata t%0d c%0d: got %h expected %h", t, c, bus.cpu_rdata, rd_exp); end
                end
                rd_pend = 1'b0;
                total++; if (bus.cpu_stall !== exp_stall) begin bad++; $display("FAIL rand_stall t%0d c%0d: got %b expected %b", t, c, bus.cpu_stall, exp_stall); end
                total++; if (bus.dbg_ack !== exp_ack) begin bad++; $display("FAIL rand_ack t%0d c%0d: got %b expected %b", t, c, bus.dbg_ack, exp_ack); end
                if (exp_ack && !dwe && dv) begin
                    total++; if (bus.dbg_rdata !== exp_rd) begin bad++; $display("FAIL rand_dbg_rdata t%0d: got %h expected %h", t, bus.dbg_rdata, exp_rd); end
                end
                if (exp_ack || bus.dbg_ack) acked = 1'b1;
                if (is_issue) begin
                    if (dwe) ref_write(da, dd);
                    else begin exp_rd = ref_mem[da]; dv = ref_valid[da]; end
                end
                if (granted) begin
                    if (cwe) ref_write(ca, cd);
                    else if (ref_valid[ca]) begin rd_pend = 1'b1; rd_exp = ref_mem[ca]; end
                end
                next_cycle();
            end
            if (!acked) begin total++; bad++; $display("FAIL rand_timeout t%0d: got no ack expected ack", t); end
            set_idle();
            @(negedge clock);
            if (rd_pend) begin
                total++; if (bus.cpu_rdata !== rd_exp) begin bad++; $display("FAIL rand_cpu_rdata_tail t%0d: got %h expected %h", t, bus.cpu_rdata, rd_exp); end
            end
            next_cycle();
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_dbg_write_idle();
        test_starvation();
        test_lock();
        test_back_to_back();
        test_reset_in_issue();
        test_collision();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port 16Kx16 SPRAM data memory between the rj32 CPU data port and a debug/loader port, so a host can peek and poke data memory while the CPU runs or is frozen. Sits between the CPU's `A_data`/`D_out`/`w_en`/`D_in` signals and the SB_SPRAM256KA primitive, in the 12 MHz CPU clock domain. The CPU has priority. A starvation counter guarantees the debug port a slot, and a lock input freezes the CPU entirely.

## Interface
Parameters:
- `ADDR_W`, 14: word address width.
- `DATA_W`, 16: data width.
- `MAX_WAIT`, 15: maximum cycles a pending debug request waits before it is forced through. Range 1..255.

Ports:
- `clock`  in  1: CPU clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `cpu_req`  in  1: CPU access request, valid this cycle.
- `cpu_we`  in  1: CPU write enable.
- `cpu_addr`  in  ADDR_W: CPU word address.
- `cpu_wdata`  in  DATA_W: CPU write data.
- `cpu_stall`  out  1: CPU access not performed this cycle; hold request.
- `cpu_rdata`  out  DATA_W: CPU read data.
- `dbg_req`  in  1: debug request; held until `dbg_ack`.
- `dbg_we`  in  1: debug write enable.
- `dbg_addr`  in  ADDR_W: debug word address.
- `dbg_wdata`  in  DATA_W: debug write data.
- `dbg_lock`  in  1: stall the CPU unconditionally.
- `dbg_ack`  out  1: one-cycle completion pulse.
- `dbg_rdata`  out  DATA_W: debug read data, valid while `dbg_ack` is high.
- `ram_addr`  out  ADDR_W: to SPRAM `ADDRESS`.
- `ram_din`  out  DATA_W: to SPRAM `DATAIN`.
- `ram_wren`  out  1: to SPRAM `WREN`.
- `ram_maskwren`  out  4: to SPRAM `MASKWREN`; equals `{4{ram_wren}}`.
- `ram_dout`  in  DATA_W: from SPRAM `DATAOUT`; registered, 1-cycle latency.

## Operation
FSM states:
- IDLE: no debug request pending.
- PEND: debug request waiting for a slot.
- ISSUE: debug access driven to the RAM this cycle.
- ACK: debug read data returned.

Transitions:
- IDLE→PEND when `dbg_req` is high.
- PEND→ISSUE when any of these holds: `cpu_req` is low, `dbg_lock` is high, or `wait_cnt==MAX_WAIT`.
- ISSUE→ACK unconditionally.
- ACK→IDLE unconditionally. `dbg_req` is ignored in ACK; the requester deasserts it or presents a new request from the following cycle.

Grant and RAM-side rules:
- Debug owns the RAM only in ISSUE.
- Otherwise the CPU owns the RAM when `cpu_req & ~dbg_lock`.
- When neither owns the RAM, `ram_wren=0` and the address/data muxes select the CPU port.
- `cpu_stall = cpu_req & (dbg_lock | state==ISSUE)`. This is combinational.

Counter and data rules:
- `wait_cnt` (8-bit) clears on entry to PEND, increments each cycle in PEND, and saturates at `MAX_WAIT`.
- `dbg_ack` and `dbg_rdata` are registered: in ACK, `dbg_ack=1` and `dbg_rdata` holds the `ram_dout` capture.
- `dbg_ack` pulses for debug writes as well; `dbg_rdata` is then don't-care but stable.
- `cpu_rdata = ram_dout` (pass-through). It is valid the cycle after the granted CPU read.

Boundary conditions:
- A CPU write and a debug write to the same address in the same cycle cannot both occur. Debug in ISSUE blocks the CPU, and the CPU retries the following cycle.
- `dbg_lock` falling mid-transaction does not abort a debug access in flight.
- `reset` mid-ISSUE: `ram_wren` drops in the cycle after reset is sampled. No ack is produced.

Reset values:
- state=IDLE.
- `wait_cnt=0`.
- `dbg_ack=0`.
- `dbg_rdata=0`.
- `cpu_stall` follows its combinational equation; it is 0 with `dbg_lock` low.

## Timing
- CPU access, no contention: 0 added latency. Read data appears the cycle after the request.
- Debug access, CPU idle: request at cycle N, PEND at N+1, ISSUE at N+2, `dbg_ack` at N+3.
- Debug access, CPU continuously busy: ISSUE occurs at most `MAX_WAIT`+1 cycles after PEND entry.
- Each forced debug slot costs the CPU exactly one stall cycle.
- All RAM-side outputs are combinational from registered state and the port inputs. The SPRAM is clocked by `clock` with no inversion.

## Structure
- Shared package: FSM state encoding (`DMA_IDLE`, `DMA_PEND`, `DMA_ISSUE`, `DMA_ACK`, 2 bits) and the default `MAX_WAIT`.
- Single module, no sub-modules. The saturating counter is inline.
- The top level instantiates this block between `rj32` and `SB_SPRAM256KA`.

## Test plan
- Reset, then debug write 0x1234 to address 0x0005 with the CPU idle → `dbg_ack` 3 cycles after `dbg_req`; a following CPU read of 0x0005 returns 0x1234 with `cpu_stall` never asserted.
- CPU `cpu_req` held high every cycle, debug read pending, `MAX_WAIT=15` → `dbg_ack` within 18 cycles of `dbg_req`; `cpu_stall` high exactly 1 cycle.
- `dbg_lock=1` with `cpu_req=1` → `cpu_stall=1` and `ram_wren=0` every cycle; a debug read of 0x3FFF completes in 3 cycles.
- Back-to-back debug requests (`dbg_req` held through ACK) → second ack no earlier than 4 cycles after the first; no double write observed at the RAM.
- `reset` asserted while in ISSUE → next cycle state=IDLE, `dbg_ack=0`, `ram_wren=0`.
- CPU write and debug write to 0x0100 (0xAAAA vs 0x5555) arriving together → the debug write commits in ISSUE and the CPU write commits one cycle later; final read returns 0xAAAA.
